rx_frame_checker: RTL and testbench
===================================

# rx_frame_checker

Consumes the deserializer's per-frame outputs (data byte, parity bit, stop bit) and checks parity and framing. It buffers each completed frame with its error flags in a small FIFO and presents it to the host side over a valid/ready handshake. Sits directly downstream of the UART receive deserializer, in the same `clk` domain.

## Interface
Parameters:
- FIFO_DEPTH, 8: entries in the frame buffer; power of two, 2..64.
- ODD_PARITY, 0: 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- byte_in  input  8  deserialized data byte; stable while byte_valid high.
- byte_valid  input  1  level; rising edge = byte complete.
- parity_in  input  1  received parity bit; stable while parity_valid high.
- parity_valid  input  1  level; rising edge = parity bit sampled.
- stop_in  input  1  received stop bit; stable while stop_valid high.
- stop_valid  input  1  level; rising edge = stop bit sampled.
- out_data  output  8  head-of-FIFO data byte.
- out_parity_err  output  1  head entry parity mismatch.
- out_frame_err  output  1  head entry stop bit was 0.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head when out_valid & out_ready.
- overrun  output  1  sticky: a frame was dropped because the FIFO was full.
- protocol_err  output  1  sticky: an event arrived out of sequence.
- clear_flags  input  1  synchronous one-cycle clear of overrun and protocol_err.

## Operation
- Edge detect: each *_valid input is registered once; event = input & ~registered. The registered copies reset to 0, so a valid input held high at reset release produces an event in the first cycle after release.
- FSM states and transitions:
  - WAIT_BYTE: byte event latches byte_in, goes to WAIT_PARITY.
  - WAIT_PARITY: parity event latches parity_err = ^{byte, parity_in} ^ ODD_PARITY ^ 1'b0 mismatch, goes to WAIT_STOP.
  - WAIT_STOP: stop event latches frame_err = ~stop_in, goes to PUSH.
  - PUSH: writes {frame_err, parity_err, byte} to the FIFO for one cycle, returns to WAIT_BYTE.
- Parity rule: parity_err = (^byte ^ parity_in) != ODD_PARITY.
- Out-of-sequence events, e.g. a byte event in WAIT_PARITY/WAIT_STOP, or a parity/stop event in WAIT_BYTE:
  - Set protocol_err.
  - A byte event restarts capture with the new byte, dropping the partial frame.
  - Other stray events are ignored.
  - Events arriving while in PUSH are treated as if in WAIT_BYTE.
- FIFO write in PUSH:
  - If full and no pop this cycle: entry dropped, overrun set.
  - If full with simultaneous pop: write accepted.
- Pop: occurs when out_valid & out_ready. Pop while empty is ignored.
- Output gating: out_data, out_parity_err and out_frame_err read 0 whenever out_valid is low.
- Flag clear priority: clear_flags beats a same-cycle set; the flag reads 0 next cycle and the new event is lost.
- Pointers: log2(FIFO_DEPTH)+1 bits, wrapping naturally. Full = MSBs differ and LSBs equal.

## Timing
- Reset values: FSM WAIT_BYTE; pointers 0; out_valid, out_data, out_parity_err, out_frame_err, overrun, protocol_err all 0; latched frame fields 0.
- Latency: stop_valid first high in cycle N → PUSH in N+1 → out_valid high in N+2 (empty FIFO case).
- Throughput: one frame per 4 cycles minimum (byte, parity, stop, push).
- Pop: the pop at edge k shows the next head, or out_valid low, after edge k.
- Reset mid-frame: partial frame and all FIFO contents discarded immediately (asynchronous).

## Configuration
- RX_PARITY_CHECK_EN defined: behaviour as above.
- RX_PARITY_CHECK_EN undefined:
  - No WAIT_PARITY state; WAIT_BYTE goes directly to WAIT_STOP.
  - parity_in and parity_valid are ignored and raise no protocol_err.
  - out_parity_err is tied to 0 and the stored entry is 9 bits.

## Structure
- Package rx_frame_pkg:
  - FSM state enum.
  - DATA_W = 8.
  - Entry field offsets (DATA_LSB, PERR_BIT, FERR_BIT).
- Sub-module rx_frame_fifo:
  - Synchronous-write, show-ahead FIFO with push/pop/full/empty.
  - Parameterised by depth and entry width.
  - Checker top holds edge detection, FSM, error computation and sticky flags.

## Test plan
- Byte 0x55, parity 0, stop 1, ODD_PARITY=0 → out_data=0x55, parity_err=0, frame_err=0; out_valid rises 2 cycles after stop_valid rise.
- Byte 0x01, parity 0, stop 0 → entry 0x01 with parity_err=1, frame_err=1.
- FIFO_DEPTH=4, out_ready=0, 5 frames → 4 stored in order, overrun=1. Then clear_flags → overrun=0; drain returns the first 4 bytes.
- Full FIFO, out_ready=1 in the PUSH cycle → no overrun; the 5th byte is delivered after 4 pops.
- Byte event, then a second byte event (0xA3) before parity → protocol_err=1; the frame completes with 0xA3.
- Assert reset during WAIT_STOP with 2 entries queued → out_valid=0 immediately, FSM WAIT_BYTE, the next full frame delivered normally.

Source files
------------

// File: rtl/rx_frame_pkg.sv
// Shared types and entry layout for the UART receive frame checker.
// Entry layout depends on RX_PARITY_CHECK_EN (parity flag stored only when defined).
package rx_frame_pkg;

  typedef enum logic [1:0] {
    WAIT_BYTE   = 2'd0,
    WAIT_PARITY = 2'd1,
    WAIT_STOP   = 2'd2,
    PUSH        = 2'd3
  } state_e;

  localparam int DATA_W   = 8;
  localparam int DATA_LSB = 0;
  localparam int PERR_BIT = 8;
`ifdef RX_PARITY_CHECK_EN
  localparam int FERR_BIT = 9;
`else
  localparam int FERR_BIT = 8;
`endif
  localparam int ENTRY_W  = FERR_BIT + 1;

endpackage

// File: rtl/rx_frame_fifo.sv
// Show-ahead FIFO with synchronous write; head entry is visible combinationally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module rx_frame_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, rdPtr_q;
  logic             doPush, doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + {{AW{1'b0}}, 1'b1};
      if (doPop)  rdPtr_q <= rdPtr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: the checker gates every output field with out_valid.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/rx_frame_checker.sv
// Parity/framing checker behind the UART deserializer, buffering checked frames in a FIFO.
// Define RX_PARITY_CHECK_EN to include the parity stage; otherwise parity inputs are ignored.
module rx_frame_checker
  import rx_frame_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  input  logic              parity_in,
  input  logic              parity_valid,
  input  logic              stop_in,
  input  logic              stop_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity_err,
  output logic              out_frame_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              protocol_err,
  input  logic              clear_flags
);

`ifdef RX_PARITY_CHECK_EN
  localparam state_e AFTER_BYTE = WAIT_PARITY;
`else
  localparam state_e AFTER_BYTE = WAIT_STOP;
`endif

  state_e              state_q;
  logic [DATA_W-1:0]   byte_q;
  logic                ferr_q;
  logic                byteValid_q, stopValid_q;
  logic                byteEv, parityEv, stopEv;
  logic                overrun_q, overrun_d, protoErr_q, protoErr_d, protoSet;
  logic                pushEn, popEn, fifoFull, fifoEmpty;
  logic [ENTRY_W-1:0]  entry, headEntry;

`ifdef RX_PARITY_CHECK_EN
  logic                parityValid_q, perr_q;
  assign parityEv = parity_valid & ~parityValid_q;
  assign entry    = {ferr_q, perr_q, byte_q};
`else
  logic                unusedParity;
  assign unusedParity = ^{parity_in, parity_valid};
  assign parityEv     = 1'b0;
  assign entry        = {ferr_q, byte_q};
`endif

  assign byteEv = byte_valid & ~byteValid_q;
  assign stopEv = stop_valid & ~stopValid_q;

  always_comb begin
    protoSet = 1'b0;
    case (state_q)
      WAIT_BYTE, PUSH: protoSet = stopEv | parityEv;
      WAIT_PARITY:     protoSet = byteEv | stopEv;
      WAIT_STOP:       protoSet = byteEv | parityEv;
      default:         protoSet = 1'b0;
    endcase
    // A clear in the same cycle as a new error wins; that error is lost.
    overrun_d  = clear_flags ? 1'b0 : (overrun_q | (pushEn & fifoFull & ~popEn));
    protoErr_d = clear_flags ? 1'b0 : (protoErr_q | protoSet);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= WAIT_BYTE;
      byte_q        <= '0;
      ferr_q        <= 1'b0;
      byteValid_q   <= 1'b0;
      stopValid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      protoErr_q    <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
      parityValid_q <= 1'b0;
      perr_q        <= 1'b0;
`endif
    end else begin
      byteValid_q <= byte_valid;
      stopValid_q <= stop_valid;
      overrun_q   <= overrun_d;
      protoErr_q  <= protoErr_d;
`ifdef RX_PARITY_CHECK_EN
      parityValid_q <= parity_valid;
`endif
      case (state_q)
        WAIT_BYTE, PUSH: begin
          if (byteEv) begin
            byte_q  <= byte_in;
            state_q <= AFTER_BYTE;
          end else begin
            state_q <= WAIT_BYTE;
          end
        end
`ifdef RX_PARITY_CHECK_EN
        WAIT_PARITY: begin
          if (byteEv) begin
            byte_q <= byte_in;
          end else if (parityEv) begin
            perr_q  <= ((^byte_q) ^ parity_in) != ODD_PARITY;
            state_q <= WAIT_STOP;
          end
        end
`endif
        WAIT_STOP: begin
          // A new byte mid-frame abandons the partial frame and restarts capture.
          if (byteEv) begin
            byte_q  <= byte_in;
            state_q <= AFTER_BYTE;
          end else if (stopEv) begin
            ferr_q  <= ~stop_in;
            state_q <= PUSH;
          end
        end
        default: state_q <= WAIT_BYTE;
      endcase
    end
  end

  assign pushEn = (state_q == PUSH);
  assign popEn  = out_ready & ~fifoEmpty;

  rx_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (pushEn),
    .wdata_i (entry),
    .pop_i   (popEn),
    .rdata_o (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign out_valid     = ~fifoEmpty;
  assign out_data      = out_valid ? headEntry[DATA_LSB +: DATA_W] : '0;
  assign out_frame_err = out_valid & headEntry[FERR_BIT];
`ifdef RX_PARITY_CHECK_EN
  assign out_parity_err = out_valid & headEntry[PERR_BIT];
`else
  assign out_parity_err = 1'b0;
`endif
  assign overrun      = overrun_q;
  assign protocol_err = protoErr_q;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Scoreboard bench for rx_frame_checker (FIFO_DEPTH=4, even parity).
// Expected parity flags are forced to 0 when RX_PARITY_CHECK_EN is undefined.
module tb_rx_frame_checker;

`ifdef RX_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0, parity_in = 1'b0, parity_valid = 1'b0;
  logic       stop_in = 1'b0, stop_valid = 1'b0, out_ready = 1'b0, clear_flags = 1'b0;
  logic [7:0] out_data;
  logic       out_parity_err, out_frame_err, out_valid, overrun, protocol_err;

  logic [9:0] expQ [$];
  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  rx_frame_checker #(.FIFO_DEPTH(4), .ODD_PARITY(1'b0)) dut (
    .clk(clk), .reset(reset),
    .byte_in(byte_in), .byte_valid(byte_valid),
    .parity_in(parity_in), .parity_valid(parity_valid),
    .stop_in(stop_in), .stop_valid(stop_valid),
    .out_data(out_data), .out_parity_err(out_parity_err), .out_frame_err(out_frame_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .protocol_err(protocol_err), .clear_flags(clear_flags)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] mkEntry(input logic [7:0] b, input logic perrHand, input logic ferr);
    return {ferr, perrHand & PCHK, b};
  endfunction

  // Monitor: every accepted handshake must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_entry: got 0x%0h, expected no entry",
                   {out_frame_err, out_parity_err, out_data});
        end else begin
          checkOutput("entry", {22'd0, out_frame_err, out_parity_err, out_data}, {22'd0, expQ.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic [7:0] b, input logic p, input logic s,
                               input bit popInPush, input bit stored, input logic perrHand);
    byte_in = b;    byte_valid = 1'b1;   step(); byte_valid = 1'b0;
    parity_in = p;  parity_valid = 1'b1; step(); parity_valid = 1'b0;
    stop_in = s;    stop_valid = 1'b1;   step(); stop_valid = 1'b0;
    if (stored) expQ.push_back(mkEntry(b, perrHand, ~s));
    if (popInPush) out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && out_valid; i++) step();
    out_ready = 1'b0;
    checkOutput("drain_valid_low", out_valid, 0);
    checkOutput("drain_data_gated", out_data, 0);
    checkOutput("scoreboard_empty", expQ.size(), 0);
  endtask

  task automatic pulseClear();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
  endtask

  initial begin
    #12;
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_data", out_data, 0);
    checkOutput("reset_perr", out_parity_err, 0);
    checkOutput("reset_ferr", out_frame_err, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_proto", protocol_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step();

    // 0x55 with even parity bit 0: clean frame, checking stop-to-valid latency
    byte_in = 8'h55; byte_valid = 1'b1;   step(); byte_valid = 1'b0;
    parity_in = 1'b0; parity_valid = 1'b1; step(); parity_valid = 1'b0;
    stop_in = 1'b1; stop_valid = 1'b1;    step(); stop_valid = 1'b0;
    checkOutput("latency_n1_valid", out_valid, 0);
    step();
    checkOutput("latency_n2_valid", out_valid, 1);
    checkOutput("latency_n2_data", out_data, 8'h55);
    expQ.push_back(mkEntry(8'h55, 1'b0, 1'b0));
    drain();

    // 0x01 has odd weight with parity 0, and stop 0 gives a framing error
    applyStimulus(8'h01, 1'b0, 1'b0, 0, 1, 1'b1);
    drain();

    // Five frames into a 4-deep FIFO with no consumer: fifth frame dropped
    applyStimulus(8'h11, 1'b0, 1'b1, 0, 1, 1'b0);
    applyStimulus(8'h07, 1'b0, 1'b1, 0, 1, 1'b1);
    applyStimulus(8'h80, 1'b1, 1'b1, 0, 1, 1'b0);
    applyStimulus(8'h3C, 1'b1, 1'b0, 0, 1, 1'b1);
    applyStimulus(8'hE2, 1'b0, 1'b1, 0, 0, 1'b0);
    checkOutput("overrun_set", overrun, 1);
    checkOutput("overrun_no_proto", protocol_err, 0);
    pulseClear();
    checkOutput("overrun_cleared", overrun, 0);
    drain();

    // Full FIFO with a pop in the PUSH cycle: the fifth frame is accepted
    applyStimulus(8'h21, 1'b0, 1'b1, 0, 1, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b1, 0, 1, 1'b0);
    applyStimulus(8'h23, 1'b0, 1'b1, 0, 1, 1'b1);
    applyStimulus(8'h24, 1'b0, 1'b1, 0, 1, 1'b0);
    applyStimulus(8'h25, 1'b1, 1'b1, 1, 1, 1'b0);
    checkOutput("full_pop_no_overrun", overrun, 0);
    drain();

    // Second byte before parity restarts capture with 0xA3
    byte_in = 8'h10; byte_valid = 1'b1; step(); byte_valid = 1'b0; step();
    byte_in = 8'hA3; byte_valid = 1'b1; step(); byte_valid = 1'b0;
    parity_in = 1'b0; parity_valid = 1'b1; step(); parity_valid = 1'b0;
    stop_in = 1'b1; stop_valid = 1'b1; step(); stop_valid = 1'b0;
    expQ.push_back(mkEntry(8'hA3, 1'b0, 1'b0));
    step();
    checkOutput("restart_proto_set", protocol_err, 1);
    pulseClear();
    checkOutput("restart_proto_cleared", protocol_err, 0);
    drain();

    // Stray stop event while idle: flagged and otherwise ignored
    stop_in = 1'b1; stop_valid = 1'b1; step(); stop_valid = 1'b0; step();
    checkOutput("stray_stop_proto", protocol_err, 1);
    checkOutput("stray_stop_no_push", out_valid, 0);
    pulseClear();

    // Async reset mid-frame with two entries queued
    applyStimulus(8'h31, 1'b1, 1'b1, 0, 1, 1'b0);
    applyStimulus(8'h32, 1'b1, 1'b1, 0, 1, 1'b0);
    checkOutput("pre_reset_valid", out_valid, 1);
    byte_in = 8'h40; byte_valid = 1'b1; step(); byte_valid = 1'b0;
    parity_in = 1'b1; parity_valid = 1'b1; step(); parity_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_valid", out_valid, 0);
    expQ.delete();
    step();
    reset = 1'b0;
    step();
    applyStimulus(8'h66, 1'b0, 1'b1, 0, 1, 1'b0);
    checkOutput("post_reset_proto", protocol_err, 0);
    drain();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
